comp_seq_ctrl: RTL

COMP_SEQ_CTRL -- requirements
Module: comp_seq_ctrl

---
 rtl/comp_seq_if.sv | 32 +++
 rtl/comp_seq_ctrl.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/comp_seq_if.sv
// comp_seq_if
// Request/result handshake bundle for comp_seq_ctrl.
//   start_valid/start_ready : request handshake, operands in1/in2 and signed_mode
//   res_valid/res_ready     : result handshake, a_less_b/a_greater_b/equal
//   slice_err, busy         : status
// Handshake rule (both channels): a transfer happens on a rising clk edge
// where valid and ready are both high; the producer holds its payload
// stable while valid is high and ready is low.
interface comp_seq_if;
  logic        start_valid;
  logic        start_ready;
  logic [15:0] in1;
  logic [15:0] in2;
  logic        signed_mode;
  logic        res_valid;
  logic        res_ready;
  logic        a_less_b;
  logic        a_greater_b;
  logic        equal;
  logic        slice_err;
  logic        busy;

  modport slave (
    input  start_valid, in1, in2, signed_mode, res_ready,
    output start_ready, res_valid, a_less_b, a_greater_b, equal, slice_err, busy
  );

  modport master (
    output start_valid, in1, in2, signed_mode, res_ready,
    input  start_ready, res_valid, a_less_b, a_greater_b, equal, slice_err, busy
  );
endinterface

// File: rtl/comp_seq_ctrl.sv
// comp_seq_ctrl
// Compares two 16-bit operands by walking them one nibble at a time, most
// significant first, through an external combinational 4-bit comparator
// slice. Stops at the first nibble that differs.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   bus (slave)         : request/result handshake, see comp_seq_if
//   slice_in1/slice_in2 : nibbles driven to the shared slice (0 outside SCAN)
//   slice_lt/gt/eq      : slice results, same cycle
//   dbg_state           : current FSM state (0 IDLE, 1 SCAN, 2 DONE)
module comp_seq_ctrl #(
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  comp_seq_if.slave   bus,
  output logic [3:0]  slice_in1,
  output logic [3:0]  slice_in2,
  input  logic        slice_lt,
  input  logic        slice_gt,
  input  logic        slice_eq,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic        sgn_q, sgn_d;
  logic        lt_q, lt_d;
  logic        gt_q, gt_d;
  logic        eq_q, eq_d;
  logic        err_q, err_d;

  logic [3:0]  nib_a, nib_b;
  logic        one_hot;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= 2'd3;
      a_q     <= 16'h0;
      b_q     <= 16'h0;
      sgn_q   <= 1'b0;
      lt_q    <= 1'b0;
      gt_q    <= 1'b0;
      eq_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      lt_q    <= lt_d;
      gt_q    <= gt_d;
      eq_q    <= eq_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    nib_a = a_q[{idx_q, 2'b00} +: 4];
    nib_b = b_q[{idx_q, 2'b00} +: 4];
    // Flipping the sign bit of the top nibble maps two's-complement order
    // onto unsigned order, so the slice itself stays unsigned.
    if (idx_q == 2'd3 && sgn_q) begin
      nib_a[3] = ~nib_a[3];
      nib_b[3] = ~nib_b[3];
    end
    one_hot = ({slice_lt, slice_gt, slice_eq} == 3'b100) ||
              ({slice_lt, slice_gt, slice_eq} == 3'b010) ||
              ({slice_lt, slice_gt, slice_eq} == 3'b001);
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    a_d       = a_q;
    b_d       = b_q;
    sgn_d     = sgn_q;
    lt_d      = lt_q;
    gt_d      = gt_q;
    eq_d      = eq_q;
    err_d     = err_q;
    slice_in1 = 4'h0;
    slice_in2 = 4'h0;

    case (state_q)
      IDLE: begin
        if (bus.start_valid) begin
          a_d     = bus.in1;
          b_d     = bus.in2;
          sgn_d   = bus.signed_mode & SIGNED_EN;
          idx_d   = 2'd3;
          state_d = SCAN;
        end
      end
      SCAN: begin
        slice_in1 = nib_a;
        slice_in2 = nib_b;
        if (!one_hot) begin
          err_d   = 1'b1;
          lt_d    = 1'b0;
          gt_d    = 1'b0;
          eq_d    = 1'b0;
          state_d = DONE;
        end else if (slice_lt || slice_gt) begin
          lt_d    = slice_lt;
          gt_d    = slice_gt;
          eq_d    = 1'b0;
          state_d = DONE;
        end else if (idx_q == 2'd0) begin
          lt_d    = 1'b0;
          gt_d    = 1'b0;
          eq_d    = 1'b1;
          state_d = DONE;
        end else begin
          idx_d = idx_q - 2'd1;
        end
      end
      DONE: begin
        if (bus.res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.start_ready = (state_q == IDLE);
  assign bus.res_valid   = (state_q == DONE);
  assign bus.busy        = (state_q != IDLE);
  assign bus.a_less_b    = lt_q;
  assign bus.a_greater_b = gt_q;
  assign bus.equal       = eq_q;
  assign bus.slice_err   = err_q;
  assign dbg_state       = state_q;

endmodule
